fsm_seq_detect: RTL and testbench
=================================

Name: fsm_seq_detect

Overview:
- Serial bit-pattern detector built as a Moore finite state machine.
- Samples a 1-bit input stream once per clock and flags every occurrence of the pattern 1-1-0-1 in arrival order (oldest bit first).
- Raises a one-cycle pulse when the pattern completes.
- Used as a stand-alone stream monitor, fed by any registered serial source in the same clock domain.

Parameters:
- OVERLAP, 1: 1 = overlapping matches allowed (the trailing bits of a match may start the next match); 0 = the detector restarts from scratch after each match.

Ports:
- clk  input  1  System clock; all state updates on the rising edge.
- rst_n  input  1  Reset, synchronous and active-high. The name is kept; the reset is asserted when the signal is 1.
- i_val  input  1  Serial data bit, sampled on every rising clk edge while reset is deasserted.
- o_val  output  1  Match flag. High for exactly one cycle per detected 1101.

Behaviour:
- State encoding uses five states:
  - IDLE: no prefix matched.
  - S1: "1" matched.
  - S11: "11" matched.
  - S110: "110" matched.
  - MATCH: "1101" complete.
- The state register is updated only on the rising edge of clk. Encoding is free (binary or one-hot); unused encodings go to IDLE on the next edge.
- Reset: rst_n=1 at a rising edge forces state=IDLE regardless of i_val.
  - o_val=0 from that edge onward.
  - Reset dominates all transitions, including a pending MATCH.
  - Reset mid-pattern discards the partial prefix.
- Transitions (i_val=0 / i_val=1):
  - IDLE: IDLE / S1
  - S1: IDLE / S11
  - S11: S110 / S11 (extra leading 1s keep "11")
  - S110: IDLE / MATCH
  - MATCH, OVERLAP=1: IDLE / S11 (the trailing "1" plus the new "1" form "11")
  - MATCH, OVERLAP=0: IDLE / S1
- Output: o_val = (state == MATCH). It is decoded from the state register only, with no combinational path from i_val.
- Latency: o_val is high during the clock cycle immediately following the edge that samples the final '1' of the pattern. It drops at the next edge unless that edge completes another match.
- Back-to-back matches cannot occur on consecutive cycles because the pattern length is 4, so o_val never stays high more than one cycle.
- Minimum spacing between pulses:
  - OVERLAP=1: 3 cycles (e.g. 1101101 → pulses after bit 4 and bit 7).
  - OVERLAP=0: 4 cycles.
- A pattern straddling reset release is not detected. Only bits sampled at edges with rst_n=0 count.
- The design holds no other storage and has no counters.

Test Plan:
- Reset: hold rst_n=1 for 2 edges with i_val toggling → o_val=0 and state=IDLE throughout. Release rst_n → first sampled bit starts detection.
- Single match: after reset drive 1,1,0,1,0,0 on successive edges → o_val=1 only in the cycle after the 4th edge, 0 elsewhere.
- Overlap: drive 1,1,0,1,1,0,1 with OVERLAP=1 → two pulses, after edges 4 and 7.
  - Same stimulus with OVERLAP=0 → one pulse, after edge 4 only.
- Leading ones and near-misses: drive 1,1,1,1,0,1 → one pulse after edge 6.
  - Drive 1,1,0,0,1,1,0,1 → one pulse after edge 8; no pulse after 1,1,0,0.
- Periodic stream: feed 32'hAAACD9AA LSB-first (bit index = cycle mod 32), repeated → exactly two pulses per 32-cycle period, in the cycles following the samples of bit 14 and bit 21.
  - No pulse across the bit 31 → bit 0 wrap.
- Reset mid-operation: drive 1,1,0, then assert rst_n=1 for one edge while i_val=1, then release and drive 1 → no pulse. A subsequent full 1,1,0,1 → one pulse.

Source files
------------

// File: rtl/fsm_seq_detect_if.sv
// rtl/fsm_seq_detect_if.sv - serial bit stream in, match pulse out
interface fsm_seq_detect_if;
  logic i_val;
  logic o_val;

  modport master (output i_val, input o_val);
  modport slave  (input i_val, output o_val);
endinterface

// File: rtl/fsm_seq_detect.sv
// rtl/fsm_seq_detect.sv - Moore detector for the serial pattern 1-1-0-1
module fsm_seq_detect #(
  parameter int OVERLAP = 1
) (
  input  logic              clk,
  input  logic              rst_n,   // active-high despite the name
  fsm_seq_detect_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S11   = 3'd2,
    S110  = 3'd3,
    MATCH = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  // State register; reset wins over any pending transition, including MATCH.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; each state holds the longest matched prefix of 1101.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = bus.i_val ? S1    : IDLE;
      S1:      state_next = bus.i_val ? S11   : IDLE;
      S11:     state_next = bus.i_val ? S11   : S110;
      S110:    state_next = bus.i_val ? MATCH : IDLE;
      // With overlap the trailing 1 of the match pairs with a new 1 as "11";
      // without it the new 1 is the first bit of a fresh search.
      MATCH: begin
        if (bus.i_val) begin
          state_next = (OVERLAP != 0) ? S11 : S1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.o_val = (state == MATCH);

endmodule

// File: tb/tb_fsm_seq_detect.sv
// tb/tb_fsm_seq_detect.sv - scoreboard bench for both overlap settings
module tb_fsm_seq_detect;

  logic clk;
  logic rst_n;

  fsm_seq_detect_if ovl1_if ();
  fsm_seq_detect_if ovl0_if ();

  fsm_seq_detect #(.OVERLAP(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ovl1_if));
  fsm_seq_detect #(.OVERLAP(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(ovl0_if));

  typedef struct packed {
    logic e1;
    logic e0;
  } exp_t;

  exp_t sb[$];
  exp_t got;

  int vectors;
  int miscompares;

  // Reference: a 1101 ends here when the last four bits since reset (and,
  // without overlap, since the last match) read 1101.
  logic [3:0] h1, h0;
  int c1, c0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic drive_bit(input logic b, input logic r);
    exp_t e;
    ovl1_if.i_val = b;
    ovl0_if.i_val = b;
    rst_n = r;
    if (r) begin
      h1 = 4'd0; h0 = 4'd0; c1 = 0; c0 = 0;
      e.e1 = 1'b0; e.e0 = 1'b0;
    end else begin
      h1 = {h1[2:0], b};
      if (c1 < 4) c1++;
      e.e1 = (c1 >= 4) && (h1 == 4'b1101);
      h0 = {h0[2:0], b};
      if (c0 < 4) c0++;
      e.e0 = (c0 >= 4) && (h0 == 4'b1101);
      if (e.e0) c0 = 0;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive_bit(i[0], 1'b1);
      got = sb.pop_front();
      vectors++;
      if (ovl1_if.o_val !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_ovl1 edge %0d: o_val=%b required 0", i, ovl1_if.o_val);
      end
      vectors++;
      if (ovl0_if.o_val !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_ovl0 edge %0d: o_val=%b required 0", i, ovl0_if.o_val);
      end
    end
  endtask

  task automatic test_single_match();
    logic [5:0] seq;
    seq = 6'b110100;
    for (int i = 5; i >= 0; i--) begin
      drive_bit(seq[i], 1'b0);
      got = sb.pop_front();
      vectors++;
      if (ovl1_if.o_val !== got.e1 || ovl1_if.o_val !== (i == 2)) begin
        miscompares++;
        $display("FAIL single_ovl1 edge %0d: o_val=%b required %b", 6 - i, ovl1_if.o_val, got.e1);
      end
      vectors++;
      if (ovl0_if.o_val !== got.e0) begin
        miscompares++;
        $display("FAIL single_ovl0 edge %0d: o_val=%b required %b", 6 - i, ovl0_if.o_val, got.e0);
      end
    end
  endtask

  task automatic test_overlap();
    logic [6:0] seq;
    int p1, p0;
    seq = 7'b1101101;
    p1 = 0; p0 = 0;
    drive_bit(1'b0, 1'b1);
    got = sb.pop_front();
    for (int i = 6; i >= 0; i--) begin
      drive_bit(seq[i], 1'b0);
      got = sb.pop_front();
      p1 += int'(ovl1_if.o_val);
      p0 += int'(ovl0_if.o_val);
      vectors++;
      if (ovl1_if.o_val !== got.e1) begin
        miscompares++;
        $display("FAIL overlap_ovl1 edge %0d: o_val=%b required %b", 7 - i, ovl1_if.o_val, got.e1);
      end
      vectors++;
      if (ovl0_if.o_val !== got.e0) begin
        miscompares++;
        $display("FAIL overlap_ovl0 edge %0d: o_val=%b required %b", 7 - i, ovl0_if.o_val, got.e0);
      end
    end
    vectors++;
    if (p1 != 2) begin
      miscompares++;
      $display("FAIL overlap_count_ovl1: pulses=%0d required 2", p1);
    end
    vectors++;
    if (p0 != 1) begin
      miscompares++;
      $display("FAIL overlap_count_ovl0: pulses=%0d required 1", p0);
    end
  endtask

  task automatic test_near_miss();
    logic [13:0] seq;
    int p1;
    // 1,1,1,1,0,1 then 1,1,0,0,1,1,0,1
    seq = 14'b111101_11001101;
    p1 = 0;
    drive_bit(1'b0, 1'b1);
    got = sb.pop_front();
    for (int i = 13; i >= 0; i--) begin
      drive_bit(seq[i], 1'b0);
      got = sb.pop_front();
      p1 += int'(ovl1_if.o_val);
      vectors++;
      if (ovl1_if.o_val !== got.e1) begin
        miscompares++;
        $display("FAIL near_miss_ovl1 edge %0d: o_val=%b required %b", 14 - i, ovl1_if.o_val, got.e1);
      end
      vectors++;
      if (ovl0_if.o_val !== got.e0) begin
        miscompares++;
        $display("FAIL near_miss_ovl0 edge %0d: o_val=%b required %b", 14 - i, ovl0_if.o_val, got.e0);
      end
    end
    vectors++;
    if (p1 != 2) begin
      miscompares++;
      $display("FAIL near_miss_count: pulses=%0d required 2", p1);
    end
  endtask

  task automatic test_periodic();
    logic [31:0] stream;
    logic want;
    stream = 32'hAAACD9AA;
    drive_bit(1'b0, 1'b1);
    got = sb.pop_front();
    for (int i = 0; i < 96; i++) begin
      drive_bit(stream[i % 32], 1'b0);
      got = sb.pop_front();
      want = ((i % 32) == 14) || ((i % 32) == 21);
      vectors++;
      if (ovl1_if.o_val !== got.e1 || ovl1_if.o_val !== want) begin
        miscompares++;
        $display("FAIL periodic_ovl1 cycle %0d: o_val=%b required %b", i, ovl1_if.o_val, want);
      end
      vectors++;
      if (ovl0_if.o_val !== got.e0 || ovl0_if.o_val !== want) begin
        miscompares++;
        $display("FAIL periodic_ovl0 cycle %0d: o_val=%b required %b", i, ovl0_if.o_val, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    // 1,1,0, reset with 1, then 1 (no pulse), then 1,1,0,1 (pulse),
    // then 1,1,0 and reset on the final 1 (pending match discarded)
    logic [12:0] seq;
    logic [12:0] rst;
    int p1;
    seq = 13'b110_1_1_1101_1101;
    rst = 13'b000_1_0_0000_0001;
    p1 = 0;
    drive_bit(1'b0, 1'b1);
    got = sb.pop_front();
    for (int i = 12; i >= 0; i--) begin
      drive_bit(seq[i], rst[i]);
      got = sb.pop_front();
      p1 += int'(ovl1_if.o_val);
      vectors++;
      if (ovl1_if.o_val !== got.e1) begin
        miscompares++;
        $display("FAIL reset_mid_ovl1 edge %0d: o_val=%b required %b", 13 - i, ovl1_if.o_val, got.e1);
      end
      vectors++;
      if (ovl0_if.o_val !== got.e0) begin
        miscompares++;
        $display("FAIL reset_mid_ovl0 edge %0d: o_val=%b required %b", 13 - i, ovl0_if.o_val, got.e0);
      end
    end
    vectors++;
    if (p1 != 1) begin
      miscompares++;
      $display("FAIL reset_mid_count: pulses=%0d required 1", p1);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    h1 = 4'd0; h0 = 4'd0; c1 = 0; c0 = 0;
    rst_n = 1'b1;
    ovl1_if.i_val = 1'b0;
    ovl0_if.i_val = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_match();
    test_overlap();
    test_near_miss();
    test_periodic();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
